snac_db15_reader: RTL



---
 rtl/snac_db15_reader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/snac_db15_reader.sv
// SNAC DB15 serial front end: clocks two chained 12-bit PISO registers on the
// user port and publishes two active-high joystick words once per frame.
module snac_db15_reader #(
   parameter int CLK_DIV  = 20,
   parameter int POLL_GAP = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        joy_clk,
   output logic        joy_load,
   input  logic        joy_data,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        frame_done,
   output logic [2:0]  state_dbg
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
   localparam logic [4:0]    IDX_LAST = 5'd23;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_SETUP    = 3'd2,
      ST_SHIFT_LO = 3'd3,
      ST_SHIFT_HI = 3'd4
   } state_t;

   state_t        state;
   logic [DW-1:0] div;
   logic [GW-1:0] gap;
   logic [4:0]    idx;
   logic [23:0]   shreg;
   logic [1:0]    sync_q;
   logic          tick;

   assign tick      = (div == DIV_LAST);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   // joy_data is asynchronous to clk; only sync_q[1] is ever sampled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], joy_data};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         gap        <= '0;
         idx        <= '0;
         shreg      <= '0;
         joy_clk    <= 1'b0;
         joy_load   <= 1'b1;
         joystick1  <= '0;
         joystick2  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (tick) begin
            case (state)
               ST_IDLE: begin
                  if (gap == GAP_LAST) begin
                     gap      <= '0;
                     joy_load <= 1'b0;
                     state    <= ST_LOAD;
                  end else begin
                     gap <= gap + 1'b1;
                  end
               end
               ST_LOAD: begin
                  joy_load <= 1'b1;
                  state    <= ST_SETUP;
               end
               ST_SETUP: begin
                  idx   <= '0;
                  state <= ST_SHIFT_LO;
               end
               // Sample on the last clk before joy_clk rises.
               ST_SHIFT_LO: begin
                  shreg[idx] <= sync_q[1];
                  joy_clk    <= 1'b1;
                  state      <= ST_SHIFT_HI;
               end
               ST_SHIFT_HI: begin
                  joy_clk <= 1'b0;
                  if (idx == IDX_LAST) begin
                     joystick1  <= {4'b0000, ~shreg[11:0]};
                     joystick2  <= {4'b0000, ~shreg[23:12]};
                     frame_done <= 1'b1;
                     state      <= ST_IDLE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= ST_SHIFT_LO;
                  end
               end
               default: begin
                  joy_clk  <= 1'b0;
                  joy_load <= 1'b1;
                  state    <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
